// File: rtl/seqdet_pkg.sv
// Shared types and constants for the parametrised serial sequence detector.
package seqdet_pkg;

    // Detector state encoding
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } seqdet_state_e;

    // Legal range of the pattern length parameter
    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;

endpackage : seqdet_pkg

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seqdet_sat_counter
    import seqdet_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear wins over increment; increment stops at the maximum value
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : seqdet_sat_counter

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap/non-overlap modes and a
// saturating match counter. Define SEQDET_MASK_EN to add a don't-care mask
// (mask_in, latched with load) to the pattern compare.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clr,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] mask_in,
`endif
    input  logic             overlap,
    input  logic             en,
    input  logic             w,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    // Fill counter must be able to hold PAT_W itself
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    seqdet_state_e     r_state;
    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  r_pattern;
    logic [FILL_W-1:0] r_fill;
    logic              r_z;
    logic              r_armed;

    logic [PAT_W-1:0]  w_hist_next;
    logic [PAT_W-1:0]  w_care;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_active;
    logic              w_sample;
    logic              w_full;
    logic              w_match;

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0]  r_mask;

    // Mask is captured together with the pattern; set bits are don't-care
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_mask <= '0;
        end else if (load) begin
            r_mask <= mask_in;
        end
    end

    assign w_care = ~r_mask;
`else
    assign w_care = {PAT_W{1'b1}};
`endif

    // Candidate history and fill level if this cycle's bit is accepted
    assign w_hist_next = {r_hist[PAT_W-2:0], w};
    assign w_fill_inc  = r_fill + FILL_W'(1);

    // load and clr both drop a coincident sample; IDLE ignores samples
    assign w_active = (r_state == FILL) || (r_state == RUN);
    assign w_sample = en && !load && !clr && w_active;
    assign w_full   = (r_state == RUN) || (w_fill_inc == FILL_FULL);
    assign w_match  = w_sample && w_full &&
                      (((w_hist_next ^ r_pattern) & w_care) == '0);

    // Detector FSM with registered match pulse and armed flag
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_z       <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_z <= 1'b0;
            if (load) begin
                r_pattern <= pattern_in;
                r_hist    <= '0;
                r_fill    <= '0;
                r_state   <= FILL;
                r_armed   <= 1'b1;
            end else if (clr) begin
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= r_armed ? FILL : IDLE;
            end else if (w_sample) begin
                if (w_match) begin
                    r_z <= 1'b1;
                    if (overlap) begin
                        r_hist  <= w_hist_next;
                        r_fill  <= FILL_FULL;
                        r_state <= RUN;
                    end else begin
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_state <= FILL;
                    end
                end else begin
                    r_hist <= w_hist_next;
                    if (r_state == FILL) begin
                        r_fill <= w_fill_inc;
                        if (w_full) begin
                            r_state <= RUN;
                        end
                    end
                end
            end else if (!w_active && (r_state != IDLE)) begin
                // Unused encoding: fall back to a safe state
                r_state <= IDLE;
                r_hist  <= '0;
                r_fill  <= '0;
            end
        end
    end

    seqdet_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .i_clr   (clr),
        .i_inc   (w_match),
        .o_count (match_count)
    );

    assign z     = r_z;
    assign armed = r_armed;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param. Instance u_dut uses the
// default widths; u_sat shares the same inputs with CNT_W=2 for saturation.
module tb_seq_detector_param;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b1;
    logic       clr    = 1'b0;
    logic       load   = 1'b0;
    logic [3:0] pattern_in = '0;
    logic [3:0] mask_in    = '0;
    logic       overlap = 1'b0;
    logic       en      = 1'b0;
    logic       w       = 1'b0;

    logic       z_a, armed_a;
    logic [7:0] cnt_a;
    logic       z_b, armed_b;
    logic [1:0] cnt_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clock = ~Clock;

    seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .clr         (clr),
        .load        (load),
        .pattern_in  (pattern_in),
`ifdef SEQDET_MASK_EN
        .mask_in     (mask_in),
`endif
        .overlap     (overlap),
        .en          (en),
        .w           (w),
        .z           (z_a),
        .match_count (cnt_a),
        .armed       (armed_a)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2)) u_sat (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .clr         (clr),
        .load        (load),
        .pattern_in  (pattern_in),
`ifdef SEQDET_MASK_EN
        .mask_in     (mask_in),
`endif
        .overlap     (overlap),
        .en          (en),
        .w           (w),
        .z           (z_b),
        .match_count (cnt_b),
        .armed       (armed_b)
    );

    // Count one comparison and report it if it does not hold
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given sample; outputs are stable 1 time unit after the edge
    task automatic tick(input logic e, input logic b);
        en = e;
        w  = b;
        @(posedge Clock);
        #1;
        en = 1'b0;
        w  = 1'b0;
    endtask

    // Load a pattern, optionally clearing the counter in the same cycle
    task automatic do_load(input logic [3:0] p, input logic ov, input logic with_clr);
        load       = 1'b1;
        clr        = with_clr;
        pattern_in = p;
        overlap    = ov;
        tick(1'b0, 1'b0);
        load = 1'b0;
        clr  = 1'b0;
    endtask

    // Apply n cycles (MSB first) and check z after each
    task automatic run(input string tag, input logic [15:0] env, input logic [15:0] bits,
                       input logic [15:0] expz, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            tick(env[i], bits[i]);
            check($sformatf("%s_z%0d", tag, n - 1 - i), 32'(z_a), 32'(expz[i]));
        end
    endtask

    initial begin
        // Reset
        #1 Resetn = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("rst_z", 32'(z_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_armed", 32'(armed_a), 0);
        Resetn = 1'b1;

        // No pattern loaded: samples ignored
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            check($sformatf("idle_z%0d", i), 32'(z_a), 0);
            check($sformatf("idle_cnt%0d", i), 32'(cnt_a), 0);
            check($sformatf("idle_armed%0d", i), 32'(armed_a), 0);
        end

        // 1011 overlapping, stream 1011011
        do_load(4'b1011, 1'b1, 1'b0);
        check("ld_armed", 32'(armed_a), 1);
        run("ov", 16'h007F, 16'h005B, 16'h0009, 7);
        check("ov_cnt", 32'(cnt_a), 2);

        // Same stream, non-overlapping
        do_load(4'b1011, 1'b0, 1'b1);
        check("nov_clr_cnt", 32'(cnt_a), 0);
        run("nov", 16'h007F, 16'h005B, 16'h0008, 7);
        check("nov_cnt", 32'(cnt_a), 1);

        // 1111 overlapping, ten ones with en gaps
        do_load(4'b1111, 1'b1, 1'b1);
        run("ones", 16'h1DDD, 16'h1FFF, 16'h01DD, 13);
        check("ones_cnt", 32'(cnt_a), 7);

        // 0000 overlapping, 12 zeros; narrow counter saturates at 3
        do_load(4'b0000, 1'b1, 1'b1);
        run("sat_a", 16'h000F, 16'h0000, 16'h0001, 4);
        check("sat_b1", 32'(cnt_b), 1);
        run("sat_b", 16'h0003, 16'h0000, 16'h0003, 2);
        check("sat_b3", 32'(cnt_b), 3);
        run("sat_c", 16'h003F, 16'h0000, 16'h003F, 6);
        check("sat_hold", 32'(cnt_b), 3);
        check("sat_wide", 32'(cnt_a), 9);
        clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        check("clr_cnt_b", 32'(cnt_b), 0);
        check("clr_cnt_a", 32'(cnt_a), 0);
        check("clr_armed", 32'(armed_b), 1);
        check("clr_z", 32'(z_b), 0);

        // load with en=1 mid-stream drops the sample and restarts fill
        do_load(4'b1011, 1'b1, 1'b1);
        run("pre", 16'h0007, 16'h0005, 16'h0000, 3);
        load = 1'b1;
        pattern_in = 4'b1011;
        tick(1'b1, 1'b1);
        load = 1'b0;
        check("ldsmp_z", 32'(z_a), 0);
        run("post", 16'h0007, 16'h0003, 16'h0000, 3);
        run("post2", 16'h000F, 16'h000B, 16'h0001, 4);
        check("post_cnt", 32'(cnt_a), 1);
        check("post_armed", 32'(armed_a), 1);

        // Asynchronous reset mid-operation
        Resetn = 1'b0;
        #1;
        check("arst_z", 32'(z_a), 0);
        check("arst_cnt", 32'(cnt_a), 0);
        check("arst_armed", 32'(armed_a), 0);
        check("arst_armed_b", 32'(armed_b), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            check($sformatf("after_z%0d", i), 32'(z_a), 0);
            check($sformatf("after_armed%0d", i), 32'(armed_a), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_seq_detector_param
